// File: rtl/logo_cfg_if.sv
// Register-write port of the logo overlay controller: one write per cycle
// when cfg_valid and cfg_ready are both high.
interface logo_cfg_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/logo_layer_ctrl.sv
// Four-square logo overlay controller: shadow registers committed atomically
// at frame start, plus an optional per-frame bounce of the logo origin.
module logo_layer_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  logo_cfg_if.slave   cfg,
  output logic [9:0]  org_x,
  output logic [8:0]  org_y,
  output logic [7:0]  sq_size,
  output logic [7:0]  sq_gap,
  output logic [11:0] sq_colors,
  output logic        commit_done,
  output logic        commit_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2,
    ANIM    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    REG_ORG_X  = 3'd0,
    REG_ORG_Y  = 3'd1,
    REG_SIZE   = 3'd2,
    REG_GAP    = 3'd3,
    REG_COLORS = 3'd4,
    REG_CTRL   = 3'd5,
    REG_STEP   = 3'd6
  } reg_addr_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  size;
    logic [7:0]  gap;
    logic [11:0] colors;
  } geom_t;

  localparam geom_t GEOM_RST = '{
    x:      10'd256,
    y:      9'd41,
    size:   8'd49,
    gap:    8'd31,
    colors: 12'b110_001_010_100
  };

  localparam logic [11:0] H_LIMIT = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIMIT = 12'(V_ACTIVE);

  // Full logo footprint on either axis: two squares plus the gap between them.
  function automatic logic [10:0] span(input logic [7:0] size, input logic [7:0] gap);
    return {2'b00, size, 1'b0} + {3'b000, gap};
  endfunction

  state_t      state;
  geom_t       shadow;
  geom_t       stage;
  geom_t       active;
  logic        anim_en;
  logic [3:0]  step_dx;
  logic [3:0]  step_dy;
  logic        dir_x_neg;
  logic        dir_y_neg;
  logic        ready_q;

  logic        wr_en;
  logic        arm_wr;
  logic [10:0] stage_w;
  logic [10:0] act_w;
  logic        commit_ok;
  logic [11:0] cand_x;
  logic [11:0] cand_y;
  logic        x_hold;
  logic        y_hold;
  logic [9:0]  next_x;
  logic [8:0]  next_y;

  assign cfg.cfg_ready = ready_q;
  assign wr_en         = cfg.cfg_valid & ready_q;
  assign arm_wr        = wr_en && (cfg.cfg_addr == REG_CTRL) && cfg.cfg_data[1];

  assign org_x     = active.x;
  assign org_y     = active.y;
  assign sq_size   = active.size;
  assign sq_gap    = active.gap;
  assign sq_colors = active.colors;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stage_w   = span(stage.size, stage.gap);
    act_w     = span(active.size, active.gap);
    commit_ok = 1'b0;
    cand_x    = '0;
    cand_y    = '0;
    x_hold    = 1'b0;
    y_hold    = 1'b0;
    next_x    = active.x;
    next_y    = active.y;

    commit_ok = (({2'b00, stage.x} + {1'b0, stage_w}) <= H_LIMIT) &&
                (({3'b000, stage.y} + {1'b0, stage_w}) <= V_LIMIT);

    // Moving toward zero by more than the coordinate would go negative.
    if (dir_x_neg) begin
      cand_x = {2'b00, active.x} - {8'd0, step_dx};
      x_hold = ({6'd0, step_dx} > active.x);
    end else begin
      cand_x = {2'b00, active.x} + {8'd0, step_dx};
      x_hold = ((cand_x + {1'b0, act_w}) > H_LIMIT);
    end

    if (dir_y_neg) begin
      cand_y = {3'b000, active.y} - {8'd0, step_dy};
      y_hold = ({5'd0, step_dy} > active.y);
    end else begin
      cand_y = {3'b000, active.y} + {8'd0, step_dy};
      y_hold = ((cand_y + {1'b0, act_w}) > V_LIMIT);
    end

    if (!x_hold) next_x = cand_x[9:0];
    if (!y_hold) next_y = cand_y[8:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shadow      <= GEOM_RST;
      stage       <= GEOM_RST;
      active      <= GEOM_RST;
      anim_en     <= 1'b0;
      step_dx     <= 4'd1;
      step_dy     <= 4'd1;
      dir_x_neg   <= 1'b0;
      dir_y_neg   <= 1'b0;
      ready_q     <= 1'b1;
      commit_done <= 1'b0;
      commit_err  <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      commit_err  <= 1'b0;

      if (wr_en) begin
        case (cfg.cfg_addr)
          REG_ORG_X:  shadow.x      <= cfg.cfg_data[9:0];
          REG_ORG_Y:  shadow.y      <= cfg.cfg_data[8:0];
          REG_SIZE:   shadow.size   <= cfg.cfg_data[7:0];
          REG_GAP:    shadow.gap    <= cfg.cfg_data[7:0];
          REG_COLORS: shadow.colors <= cfg.cfg_data;
          REG_CTRL:   anim_en       <= cfg.cfg_data[0];
          REG_STEP: begin
            step_dx <= cfg.cfg_data[3:0];
            step_dy <= cfg.cfg_data[7:4];
          end
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          // Arming wins over a coincident frame_start; the commit then lands next frame.
          if (arm_wr) begin
            state <= PENDING;
          end else if (frame_start && anim_en) begin
            state   <= ANIM;
            ready_q <= 1'b0;
          end
        end

        PENDING: begin
          // Snapshot before this cycle's write lands, so it cannot leak into the commit.
          if (frame_start) begin
            stage   <= shadow;
            state   <= COMMIT;
            ready_q <= 1'b0;
          end
        end

        COMMIT: begin
          if (commit_ok) begin
            active      <= stage;
            commit_done <= 1'b1;
          end else begin
            commit_err  <= 1'b1;
          end
          state   <= IDLE;
          ready_q <= 1'b1;
        end

        ANIM: begin
          active.x  <= next_x;
          active.y  <= next_y;
          shadow.x  <= next_x;
          shadow.y  <= next_y;
          dir_x_neg <= dir_x_neg ^ x_hold;
          dir_y_neg <= dir_y_neg ^ y_hold;
          state     <= IDLE;
          ready_q   <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logo_layer_ctrl.sv
// Randomized scoreboard bench for logo_layer_ctrl: a per-frame reference model
// predicts each DUT update, and a monitor compares whenever the DUT resumes.
module tb_logo_layer_ctrl;
  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  org_x;
  logic [8:0]  org_y;
  logic [7:0]  sq_size;
  logic [7:0]  sq_gap;
  logic [11:0] sq_colors;
  logic        commit_done;
  logic        commit_err;

  logo_cfg_if cfg ();

  logo_layer_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .cfg         (cfg),
    .org_x       (org_x),
    .org_y       (org_y),
    .sq_size     (sq_size),
    .sq_gap      (sq_gap),
    .sq_colors   (sq_colors),
    .commit_done (commit_done),
    .commit_err  (commit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int size;
    int gap;
    int colors;
    bit done;
    bit err;
  } view_t;

  int    checks = 0;
  int    errors = 0;
  view_t exp_q[$];

  // Reference model state, kept as plain integers.
  view_t sh;
  view_t act;
  bit    m_anim_en;
  bit    m_armed;
  bit    m_neg_x;
  bit    m_neg_y;
  int    m_dx;
  int    m_dy;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic view_t reset_view();
    view_t v;
    v.x = 256; v.y = 41; v.size = 49; v.gap = 31;
    v.colors = 12'b110_001_010_100;
    v.done = 1'b0; v.err = 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] pack(input view_t v);
    return {15'd0, 10'(v.x), 9'(v.y), 8'(v.size), 8'(v.gap), 12'(v.colors), v.done, v.err};
  endfunction

  function automatic logic [63:0] dut_view();
    return {15'd0, org_x, org_y, sq_size, sq_gap, sq_colors, commit_done, commit_err};
  endfunction

  task automatic model_write(input int a, input int d);
    case (a)
      0: sh.x = d % 1024;
      1: sh.y = d % 512;
      2: sh.size = d % 256;
      3: sh.gap = d % 256;
      4: sh.colors = d % 4096;
      5: begin
        m_anim_en = d[0];
        if (d[1]) m_armed = 1'b1;
      end
      6: begin
        m_dx = d % 16;
        m_dy = (d / 16) % 16;
      end
      default: ;
    endcase
  endtask

  task automatic model_commit(input view_t snap);
    int w;
    w = 2 * snap.size + snap.gap;
    if (snap.x + w <= H && snap.y + w <= V) begin
      act = snap;
      act.done = 1'b1;
      act.err = 1'b0;
    end else begin
      act.done = 1'b0;
      act.err = 1'b1;
    end
    exp_q.push_back(act);
    act.done = 1'b0;
    act.err = 1'b0;
  endtask

  // One axis of the bounce: step along the current direction, or reverse and stay put.
  task automatic bounce(input int pos, input int step, input int w, input int lim,
                        input bit neg, output int npos, output bit nneg);
    int cand;
    cand = neg ? pos - step : pos + step;
    if (cand < 0 || cand + w > lim) begin
      npos = pos;
      nneg = !neg;
    end else begin
      npos = cand;
      nneg = neg;
    end
  endtask

  task automatic model_anim();
    int w, nx, ny;
    bit nnx, nny;
    w = 2 * act.size + act.gap;
    bounce(act.x, m_dx, w, H, m_neg_x, nx, nnx);
    bounce(act.y, m_dy, w, V, m_neg_y, ny, nny);
    act.x = nx; act.y = ny;
    m_neg_x = nnx; m_neg_y = nny;
    sh.x = nx; sh.y = ny;
    exp_q.push_back(act);
  endtask

  // One clock of stimulus; the model follows what the DUT will see at the next edge.
  task automatic cycle(input bit v, input int a, input int d, input bit fs, output bit acc);
    view_t snap;
    bit    pre_armed;
    bit    pre_anim;
    @(negedge clk);
    cfg.cfg_valid = v;
    cfg.cfg_addr  = 3'(a);
    cfg.cfg_data  = 12'(d);
    frame_start   = fs;
    acc = v && (cfg.cfg_ready === 1'b1);
    snap = sh;
    pre_armed = m_armed;
    pre_anim = m_anim_en;
    if (acc) model_write(a, d);
    if (fs) begin
      if (pre_armed) begin
        m_armed = 1'b0;
        model_commit(snap);
      end else if (!m_armed && pre_anim) begin
        model_anim();
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, acc);
  endtask

  task automatic wr(input int a, input int d);
    bit acc;
    int n;
    n = 0;
    do begin
      cycle(1'b1, a, d, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: addr %0d not accepted within 20 cycles", a);
    end
  endtask

  task automatic frame();
    bit acc;
    cycle(1'b0, 0, 0, 1'b1, acc);
    idle(3);
  endtask

  function automatic int rand_data(input int a);
    case (a)
      0: return $urandom_range(0, 639) + 1024 * $urandom_range(0, 3);
      1: return $urandom_range(0, 479) + 512 * $urandom_range(0, 7);
      2, 3: return $urandom_range(0, 100);
      5: return $urandom_range(0, 3) + 4 * $urandom_range(0, 1023);
      default: return $urandom_range(0, 4095);
    endcase
  endfunction

  // Stream writes back-to-back with cfg_valid held high and a frame_start mid-stream.
  task automatic stream(input string name, input int n, input int fs_at);
    bit acc;
    int cyc, i, a;
    cyc = 0;
    i = 0;
    a = 2;
    while (i < n && cyc < 4 * n) begin
      if (cyc == 0 || acc) begin
        case ($urandom_range(0, 4))
          0: a = 2;
          1: a = 3;
          2: a = 4;
          3: a = 6;
          default: a = 7;
        endcase
      end
      cycle(1'b1, a, (a == 2 || a == 3) ? $urandom_range(0, 60) : rand_data(a),
            cyc == fs_at, acc);
      if (acc) i++;
      cyc++;
    end
    check({name, "_cycles"}, 64'(cyc), 64'(n + 1));
    idle(3);
  endtask

  // Monitor: one comparison per cycle; a rising cfg_ready marks a DUT update.
  initial begin : monitor
    view_t cur;
    bit    prev_ready;
    int    low_cnt;
    cur = reset_view();
    prev_ready = 1'b1;
    low_cnt = 0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (cfg.cfg_ready === 1'b1 && !prev_ready) begin
        check("stall_len", 64'(low_cnt), 64'd1);
        low_cnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: DUT resumed with no predicted result at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (cfg.cfg_ready !== 1'b1) low_cnt++;
      check("outputs", dut_view(), pack(cur));
      cur.done = 1'b0;
      cur.err = 1'b0;
      prev_ready = (cfg.cfg_ready === 1'b1);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    cfg.cfg_valid = 1'b0;
    cfg.cfg_addr  = '0;
    cfg.cfg_data  = '0;
    sh = reset_view();
    act = reset_view();
    m_anim_en = 1'b0;
    m_armed = 1'b0;
    m_neg_x = 1'b0;
    m_neg_y = 1'b0;
    m_dx = 1;
    m_dy = 1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("reset_ready", 64'(cfg.cfg_ready), 64'd1);
    check("reset_view", dut_view(), pack(reset_view()));

    // Basic commit.
    wr(0, 100);
    wr(2, 60);
    wr(5, 2);
    idle(2);
    check("t2_hold_org_x", 64'(org_x), 64'd256);
    frame();
    check("t2_org_x", 64'(org_x), 64'd100);
    check("t2_size", 64'(sq_size), 64'd60);

    // Out-of-range commit is rejected.
    wr(0, 600);
    wr(2, 49);
    wr(3, 31);
    wr(5, 2);
    frame();
    check("t3_org_x", 64'(org_x), 64'd100);

    // Bounce off the right edge: W=129, origin H-W-2.
    wr(0, H - 129 - 2);
    wr(5, 2);
    frame();
    check("t4_commit_x", 64'(org_x), 64'(H - 129 - 2));
    wr(6, 8'h14);
    wr(5, 1);
    frame();
    check("t4_frame1_x", 64'(org_x), 64'(H - 129 - 2));
    frame();
    check("t4_frame2_x", 64'(org_x), 64'(H - 129 - 6));

    // Commit and animation on the same frame: commit only, then stepping resumes.
    wr(5, 3);
    frame();
    check("t5_commit_x", 64'(org_x), 64'(H - 129 - 6));
    frame();
    check("t5_resume_x", 64'(org_x), 64'(H - 129 - 10));

    // Continuous writes across frame_start, once into ANIM and once into COMMIT.
    stream("t6_anim", 8, 3);
    wr(5, 3);
    stream("t6_commit", 8, 2);

    // Random traffic.
    for (int f = 0; f < 80; f++) begin
      bit acc;
      int a;
      for (int k = 0; k < $urandom_range(0, 4); k++) begin
        a = $urandom_range(0, 7);
        wr(a, rand_data(a));
      end
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 7);
        cycle(1'b1, a, rand_data(a), 1'b1, acc);
        idle(3);
      end else begin
        frame();
      end
    end

    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
